// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program-store geometry, loader FSM encoding, opcodes.
package td4_pkg;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int WORD_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC      = 4'b1110;
   localparam logic [3:0] OP_JMP      = 4'b1111;

   // Modulo-256 running sum; a good image plus its checksum byte totals zero.
   function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                  input logic [WORD_W-1:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/td4_prog_ram.sv
// 16x8 flop array with one write port and one combinational read port.
module td4_prog_ram
   import td4_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_rom.sv
// TD4 program store: byte-stream loader with optional checksum, holds the core in reset until a good image is resident.
module td4_prog_rom
   import td4_pkg::*;
#(
   parameter bit CHK_EN = 1'b1
)
(
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  pc,
   output logic [3:0]  cmd,
   output logic [3:0]  data,
   output logic        cpu_clr_n,
   input  logic        load_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_byte,
   output logic        ld_ready,
   output logic        err,
   output logic        loaded
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] cnt;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] rdata;
   logic              accept;
   logic              mem_we;
   logic              last_word;

   // A restart request wins over any byte offered in the same cycle.
   assign accept    = ld_valid & ld_ready & ~load_start;
   assign last_word = (cnt == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= ST_IDLE;
         cpu_clr_n <= 1'b0;
      end else begin
         state     <= state_next;
         cpu_clr_n <= (state == ST_RUN) && (state_next == ST_RUN);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt <= '0;
         acc <= '0;
      end else if (load_start) begin
         cnt <= '0;
         acc <= '0;
      end else if (mem_we) begin
         acc <= csum_add(acc, ld_byte);
         if (!last_word) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (load_start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (load_start)                 state_next = ST_LOAD;
            else if (accept && last_word)   state_next = CHK_EN ? ST_CHECK : ST_RUN;
         end
         ST_CHECK: begin
            if (load_start)  state_next = ST_LOAD;
            else if (accept) state_next = (csum_add(acc, ld_byte) == '0) ? ST_RUN : ST_ERR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ld_ready = 1'b0;
      loaded   = 1'b0;
      err      = 1'b0;
      case (state)
         ST_LOAD, ST_CHECK: ld_ready = 1'b1;
         ST_RUN:            loaded   = 1'b1;
         ST_ERR:            err      = 1'b1;
         default: ;
      endcase
      mem_we = (state == ST_LOAD) && accept;
   end

   td4_prog_ram u_ram (
      .clk   (clk),
      .clr   (clr),
      .we    (mem_we),
      .waddr (cnt),
      .wdata (ld_byte),
      .raddr (pc),
      .rdata (rdata)
   );

   assign cmd  = rdata[7:4];
   assign data = rdata[3:0];

endmodule

// File: tb/tb_td4_prog_rom.sv
// Bench for td4_prog_rom: a checksummed and an unchecked instance share one stimulus stream against a byte-list model.
`timescale 1ns/1ps
module tb_td4_prog_rom;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [3:0] pc = 4'd0;
   logic       load_start = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_byte = 8'h00;

   logic [3:0] cmd [2];
   logic [3:0] dat [2];
   logic       cpuc [2];
   logic       rdy [2];
   logic       er [2];
   logic       ld [2];

   // Instance 0 expects a checksum byte, instance 1 does not.
   td4_prog_rom #(.CHK_EN(1'b1)) u_dut_c (
      .clk(clk), .clr(clr), .pc(pc), .cmd(cmd[0]), .data(dat[0]), .cpu_clr_n(cpuc[0]),
      .load_start(load_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_ready(rdy[0]), .err(er[0]), .loaded(ld[0]));

   td4_prog_rom #(.CHK_EN(1'b0)) u_dut_n (
      .clk(clk), .clr(clr), .pc(pc), .cmd(cmd[1]), .data(dat[1]), .cpu_clr_n(cpuc[1]),
      .load_start(load_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_ready(rdy[1]), .err(er[1]), .loaded(ld[1]));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit checker_on = 1'b0;
   int acc_cnt [2];

   bit         m_loading [2];
   bit         m_run [2];
   bit         m_err [2];
   bit         m_cpu [2];
   int         m_n [2];
   logic [7:0] m_mem [2][16];

   logic [7:0] prog [16];
   logic [7:0] rnd  [16];
   logic [7:0] zero [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_loading[k] = 1'b0; m_run[k] = 1'b0; m_err[k] = 1'b0; m_cpu[k] = 1'b0; m_n[k] = 0;
         for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
      end
   endtask

   // One clock edge of the model: bytes arrive in order, the image is 16 bytes,
   // and for the checksummed part the 17th byte must bring the byte total to zero.
   task automatic model_step();
      bit         prev_run;
      logic [7:0] total;
      for (int k = 0; k < 2; k++) begin
         prev_run = m_run[k];
         if (load_start) begin
            m_loading[k] = 1'b1; m_n[k] = 0; m_run[k] = 1'b0; m_err[k] = 1'b0;
         end else if (m_loading[k] && ld_valid) begin
            if (m_n[k] < 16) begin
               m_mem[k][m_n[k]] = ld_byte;
               m_n[k]++;
               if (m_n[k] == 16 && k == 1) begin
                  m_loading[k] = 1'b0; m_run[k] = 1'b1;
               end
            end else begin
               total = ld_byte;
               for (int i = 0; i < 16; i++) total = total + m_mem[k][i];
               m_loading[k] = 1'b0;
               if (total == 8'h00) m_run[k] = 1'b1;
               else                m_err[k] = 1'b1;
            end
         end
         m_cpu[k] = prev_run && m_run[k];
      end
   endtask

   task automatic cyc();
      bit pre_rdy [2];
      pre_rdy[0] = rdy[0];
      pre_rdy[1] = rdy[1];
      @(posedge clk);
      if (clr) begin
         for (int k = 0; k < 2; k++)
            if (ld_valid && pre_rdy[k] && !load_start) acc_cnt[k]++;
         model_step();
      end
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      ld_valid = 1'b1; ld_byte = b;
      pc = 4'($urandom_range(0, 15));
      cyc();
      ld_valid = 1'b0;
      repeat (gap) begin
         ld_byte = 8'($urandom);
         cyc();
      end
   endtask

   task automatic start();
      load_start = 1'b1; cyc(); load_start = 1'b0;
   endtask

   task automatic sweep(input string tag, input logic [7:0] exp [16]);
      for (int p = 0; p < 16; p++) begin
         pc = 4'(p);
         #1;
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_cmd[%0d][%0d]", tag, k, p), cmd[k], exp[p][7:4]);
            chk($sformatf("%s_data[%0d][%0d]", tag, k, p), dat[k], exp[p][3:0]);
         end
         cyc();
      end
   endtask

   function automatic logic [7:0] csum_of(input logic [7:0] img [16]);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + img[i];
      return 8'h00 - s;
   endfunction

   always @(negedge clk) begin
      if (checker_on) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ld_ready[%0d]", k), rdy[k], m_loading[k]);
            chk($sformatf("loaded[%0d]", k), ld[k], m_run[k]);
            chk($sformatf("err[%0d]", k), er[k], m_err[k]);
            chk($sformatf("cpu_clr_n[%0d]", k), cpuc[k], m_cpu[k]);
            chk($sformatf("cmd[%0d]", k), cmd[k], m_mem[k][pc][7:4]);
            chk($sformatf("data[%0d]", k), dat[k], m_mem[k][pc][3:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = 8'hB3; prog[1] = 8'hF0;
      for (int i = 2; i < 16; i++) prog[i] = 8'h00;
      for (int i = 0; i < 16; i++) zero[i] = 8'h00;

      // Reset state
      #2 clr = 1'b0;
      model_reset();
      checker_on = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ld_ready", rdy[k], 1'b0);
         chk("rst_cpu_clr_n", cpuc[k], 1'b0);
         chk("rst_err", er[k], 1'b0);
         chk("rst_loaded", ld[k], 1'b0);
      end
      pc = 4'd15; #1;
      chk("rst_cmd_pc15", cmd[0], 4'h0);
      chk("rst_data_pc15", dat[0], 4'h0);
      @(negedge clk);
      clr = 1'b1;
      cyc();

      // Idle: loader bytes are ignored and the core stays held
      send(8'hAA, 2);
      repeat (3) cyc();
      chk("idle_ld_ready", rdy[0], 1'b0);
      chk("idle_cpu_clr_n", cpuc[0], 1'b0);

      // Nominal load with checksum 5D
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      start();
      for (int i = 0; i < 16; i++) send(prog[i], 0);
      chk("nochk_loaded_after16", ld[1], 1'b1);
      chk("chk_state_check_ready", rdy[0], 1'b1);
      send(8'h5D, 0);
      chk("nom_loaded", ld[0], 1'b1);
      chk("nom_cpu_clr_n_entry", cpuc[0], 1'b0);
      chk("nochk_ready_17th", rdy[1], 1'b0);
      chk("nochk_cpu_clr_n", cpuc[1], 1'b1);
      cyc();
      chk("nom_cpu_clr_n_next", cpuc[0], 1'b1);
      pc = 4'd0; #1;
      chk("nom_pc0_cmd", cmd[0], 4'hB);
      chk("nom_pc0_data", dat[0], 4'h3);
      pc = 4'd1; #1;
      chk("nom_pc1_cmd", cmd[0], 4'hF);
      chk("nom_pc1_data", dat[0], 4'h0);
      chk("nom_accepted_chk", acc_cnt[0], 17);
      chk("nom_accepted_nochk", acc_cnt[1], 16);
      cyc();

      // Bad checksum 5C
      start();
      for (int i = 0; i < 16; i++) send(prog[i], 0);
      send(8'h5C, 0);
      chk("bad_err", er[0], 1'b1);
      chk("bad_loaded", ld[0], 1'b0);
      chk("bad_cpu_clr_n", cpuc[0], 1'b0);
      cyc();
      chk("bad_cpu_clr_n_held", cpuc[0], 1'b0);
      start();
      chk("bad_err_cleared", er[0], 1'b0);

      // Backpressure: gapped valid, garbage bytes between pulses
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) send(rnd[i], $urandom_range(1, 3));
      send(csum_of(rnd), 2);
      send(8'h11, 1);
      chk("bp_loaded", ld[0], 1'b1);
      chk("bp_accepted_chk", acc_cnt[0], 17);
      chk("bp_accepted_nochk", acc_cnt[1], 16);
      sweep("bp_mem", rnd);

      // Restart after 7 bytes, with a byte offered on the restart edge
      start();
      for (int i = 0; i < 7; i++) send(8'($urandom), 0);
      ld_valid = 1'b1; ld_byte = 8'h77; load_start = 1'b1;
      cyc();
      ld_valid = 1'b0; load_start = 1'b0;
      for (int i = 0; i < 16; i++) rnd[i] = 8'(i * 17 + 3);
      for (int i = 0; i < 16; i++) send(rnd[i], 0);
      send(csum_of(rnd), 0);
      chk("rs_loaded", ld[0], 1'b1);
      chk("rs_err", er[0], 1'b0);
      sweep("rs_mem", rnd);

      // Asynchronous reset mid-load
      start();
      for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i), 0);
      #2 clr = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_ready", rdy[0], 1'b0);
      chk("mid_rst_cpu_clr_n", cpuc[0], 1'b0);
      sweep("mid_rst_mem", zero);
      @(negedge clk);
      clr = 1'b1;
      for (int i = 0; i < 3; i++) send(8'h12, 0);
      chk("post_rst_ready", rdy[0], 1'b0);
      chk("post_rst_loaded", ld[0], 1'b0);
      pc = 4'd0; #1;
      chk("post_rst_pc0_cmd", cmd[0], 4'h0);
      start();
      for (int i = 0; i < 16; i++) send(prog[i], 0);
      send(8'h5D, 0);
      cyc();
      chk("post_rst_run", ld[0], 1'b1);
      chk("post_rst_cpu_clr_n", cpuc[0], 1'b1);
      repeat (2) cyc();

      checker_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
